md_unit: RTL
============

Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the five-stage pipeline.
- Executes mult/multu/div/divu over a fixed multi-cycle latency, holds the HI/LO architectural registers, and services mthi/mtlo writes.
- Provides mfhi/mflo read data, which travels EX->MEM->WB as the WB-stage MDM read-data operand.
- Exposes busy/start status so the hazard unit can stall dependent MD instructions.

Parameters:
MULT_CYCLES  5   busy duration for mult/multu, in cycles (>=1)
DIV_CYCLES   10  busy duration for div/divu, in cycles (>=1)

Ports:
clk     input   1   system clock, rising edge
rst_n   input   1   asynchronous active-low reset
start   input   1   one-cycle pulse launching the operation in md_op
md_op   input   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
a       input   32  rs operand
b       input   32  rt operand
rd_sel  input   1   0 selects LO, 1 selects HI for md_rd
busy    output  1   multi-cycle operation in flight
hi      output  32  HI register
lo      output  32  LO register
md_rd   output  32  rd_sel ? hi : lo, combinational from the registers

Behaviour:
- Reset (asynchronous, rst_n=0): busy=0, hi=0, lo=0, counter=0, latched operands and op cleared. Reset mid-operation aborts the operation; no partial result is written.
- State machine IDLE/RUN:
  - IDLE: on a clock edge with start=1 and md_op in 1..4, latch a, b and md_op, load counter with the op's cycle count, go to RUN.
  - RUN: busy=1; counter decrements each edge. At the edge where counter reaches 1, write the result to HI/LO, clear busy, and return to IDLE.
- Busy timing: start sampled at edge T; busy=1 from after T to after T+N, where N is MULT_CYCLES or DIV_CYCLES. HI/LO hold the new value from edge T+N onward.
- Stall signal: the hazard unit stalls on (start | busy). md_unit itself ignores start while busy=1, so there is no preemption and operands are not relatched.
- mthi/mtlo (md_op 5/6 with start=1, IDLE only): write a into HI or LO at that edge. Single cycle; busy is not asserted. Ignored while busy.
- Arithmetic:
  - mult: {hi,lo} = signed(a) * signed(b), 64-bit.
  - multu: {hi,lo} = a * b, unsigned, 64-bit.
  - div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Boundary cases:
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (b==0) for div or divu: runs the full DIV_CYCLES, then HI/LO remain unchanged.
- Input independence: results depend only on the values latched at start. Changes on a/b/md_op during RUN have no effect.
- md_rd / hi / lo: reflect the current registers at all times, including during RUN, where they show the old values. The hazard unit guarantees mfhi/mflo are not issued while (start | busy).
- Implementation freedom: the result may be computed combinationally at latch time and released after the delay, or computed iteratively. Only the externally visible cycle counts above are required.

Test Plan:
1. Reset: rst_n=0 asynchronously mid-cycle -> busy=0, hi=lo=0 immediately without waiting for a clock edge. Repeat during a div in RUN -> HI/LO stay 0 after release.
2. mult: a=0xFFFFFFFE (-2), b=3, start pulse at edge T -> busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
3. div: a=0xFFFFFFF9 (-7), b=2 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with a=7, b=2 -> lo=3, hi=1.
4. Edge cases: div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. divu with b=0 and prior hi=0x11, lo=0x22 -> after 10 cycles hi=0x11, lo=0x22.
5. Busy interactions:
   - start=mult during div RUN -> ignored; div completes on schedule.
   - mthi a=0x1234 while busy -> ignored.
   - mthi a=0x1234 in IDLE -> hi=0x1234 next edge, busy stays 0, rd_sel=1 gives md_rd=0x1234.
6. Operand independence: start mult a=3, b=4, then toggle a and b every cycle during RUN -> lo=12, hi=0. Back-to-back: start issued the cycle after busy falls -> accepted, and its busy window begins immediately.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO, runs mult/div over a fixed
// latency and services mthi/mtlo writes, exposing busy for the hazard unit.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rd
);

  localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW        = $clog2(MaxCycles + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  // Result datapath works only from the latched operands, so input wiggles
  // during RUN cannot leak into the result.
  logic [63:0] mul_a, mul_b, prod;
  logic        is_signed_div, is_div, a_neg, b_neg, res_we;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    mul_a = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'h0, a_q};
    mul_b = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'h0, b_q};
    prod  = mul_a * mul_b;

    // Signed divide on magnitudes; this also makes 0x80000000 / -1 wrap cleanly.
    is_signed_div = (op_q == OP_DIV);
    is_div        = (op_q == OP_DIV) || (op_q == OP_DIVU);
    a_neg         = is_signed_div & a_q[31];
    b_neg         = is_signed_div & b_q[31];
    a_mag         = a_neg ? (32'd0 - a_q) : a_q;
    b_mag         = b_neg ? (32'd0 - b_q) : b_q;
    q_mag         = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    r_mag         = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    quot          = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem           = a_neg ? (32'd0 - r_mag) : r_mag;

    res_hi = is_div ? rem  : prod[63:32];
    res_lo = is_div ? quot : prod[31:0];
    res_we = !(is_div && (b_q == 32'd0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Start is only honoured in IDLE; there is no preemption of a running op.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              op_d    = md_op;
              a_d     = a;
              b_d     = b;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = md_op;
              a_d     = a;
              b_d     = b;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          if (res_we) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == RUN);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign md_rd = rd_sel ? hi_q : lo_q;

endmodule
